// File: rtl/k64_spi_pkg.sv
// k64_spi_pkg: shared FSM state type and parameter defaults for the SPI packet receiver
package k64_spi_pkg;
    typedef enum logic [1:0] {WAIT_HI, IDLE, BYTE, GAP} state_t;
    localparam int PKT_LEN_DEF    = 10;
    localparam int GAP_CYCLES_DEF = 16;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer for one async input with rise/fall detect
// ports: clk, rst (sync, active-high), d (async in), s (synchronized level), rise/fall (one-cycle edge pulses)
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);
    logic q1, q3;
    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= 1'b0;
            s  <= 1'b0;
            q3 <= 1'b0;
        end else begin
            q1 <= d;
            s  <= q1;
            q3 <= s;
        end
    end
    assign rise = s & ~q3;
    assign fall = ~s & q3;
endmodule

// File: rtl/k64_spi_rx.sv
// k64_spi_rx: SPI slave receiver assembling LSB-first bytes into CS-gap delimited packets
// ports: clk, rst (sync, active-high); spi_csn/spi_sck/spi_sdi (async SPI inputs);
// rx_data/rx_valid/rx_sop (byte out), pkt_done/pkt_len (packet close), err_short/err_len/err_seq (error pulses)
module k64_spi_rx
    import k64_spi_pkg::*;
#(
    parameter int PKT_LEN    = PKT_LEN_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_csn,
    input  logic       spi_sck,
    input  logic       spi_sdi,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sop,
    output logic       pkt_done,
    output logic [7:0] pkt_len,
    output logic       err_short,
    output logic       err_len,
    output logic       err_seq
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    logic cs_hi, cs_rise, cs_fall, sck_s, sck_rise, sck_fall, sdi_s, sdi_rise, sdi_fall;
    logic unused;
    spi_sync_edge u_csn (.clk(clk), .rst(rst), .d(spi_csn), .s(cs_hi), .rise(cs_rise), .fall(cs_fall));
    spi_sync_edge u_sck (.clk(clk), .rst(rst), .d(spi_sck), .s(sck_s), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge u_sdi (.clk(clk), .rst(rst), .d(spi_sdi), .s(sdi_s), .rise(sdi_rise), .fall(sdi_fall));
    // The FSM works on CS level, SCK rise and SDI level; the remaining detector outputs are not needed.
    assign unused = ^{cs_rise, cs_fall, sck_s, sck_fall, sdi_rise, sdi_fall};
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [7:0]    prev;
    logic [7:0]    byte_cnt;
    logic          first;
    logic [GW-1:0] gap_cnt;
    logic [2:0]    nbit;
    logic [7:0]    nbyte;
    logic          done;
    // nbit is bit_cnt after this cycle's SCK bit, so a CS rise in the same cycle sees the bit counted.
    always_comb begin
        nbit  = bit_cnt + {2'b0, sck_rise};
        nbyte = {sdi_s, shift[6:0]};
        done  = (state == BYTE) && sck_rise && (bit_cnt == 3'd7);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_HI;
            bit_cnt   <= '0;
            shift     <= '0;
            prev      <= '0;
            byte_cnt  <= '0;
            first     <= 1'b0;
            gap_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_sop    <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_len   <= '0;
            err_short <= 1'b0;
            err_len   <= 1'b0;
            err_seq   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            rx_sop    <= 1'b0;
            err_seq   <= 1'b0;
            err_short <= 1'b0;
            pkt_done  <= 1'b0;
            err_len   <= 1'b0;
            case (state)
                WAIT_HI: if (cs_hi) state <= IDLE;
                IDLE: if (!cs_hi) begin
                    state    <= BYTE;
                    bit_cnt  <= '0;
                    shift    <= '0;
                    byte_cnt <= '0;
                    first    <= 1'b1;
                end
                BYTE: begin
                    if (sck_rise) begin
                        shift[bit_cnt] <= sdi_s;
                        bit_cnt        <= nbit;
                    end
                    if (done) begin
                        rx_data  <= nbyte;
                        rx_valid <= 1'b1;
                        rx_sop   <= first;
                        err_seq  <= !first && (nbyte != prev + 8'd1);
                        prev     <= nbyte;
                        first    <= 1'b0;
                        byte_cnt <= byte_cnt + {7'b0, byte_cnt != 8'hFF};
                    end
                    // The cycle that sees CS high is the first counted gap cycle.
                    if (cs_hi) begin
                        err_short <= nbit != 3'd0;
                        bit_cnt   <= '0;
                        shift     <= '0;
                        gap_cnt   <= GW'(1);
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (!cs_hi) begin
                        state   <= BYTE;
                        gap_cnt <= '0;
                    end else if (gap_cnt >= GW'(GAP_CYCLES)) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                        if (byte_cnt != 8'd0) begin
                            pkt_done <= 1'b1;
                            pkt_len  <= byte_cnt;
                            err_len  <= byte_cnt != 8'(PKT_LEN);
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= WAIT_HI;
            endcase
        end
    end
endmodule

// File: tb/tb_k64_spi_rx.sv
// tb_k64_spi_rx: scoreboard bench driving directed SPI packets into k64_spi_rx
module tb_k64_spi_rx;
    logic       clk = 1'b0, rst = 1'b1;
    logic       spi_csn = 1'b1, spi_sck = 1'b0, spi_sdi = 1'b0;
    logic [7:0] rx_data, pkt_len;
    logic       rx_valid, rx_sop, pkt_done, err_short, err_len, err_seq;

    k64_spi_rx dut (
        .clk(clk), .rst(rst), .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .pkt_done(pkt_done),
        .pkt_len(pkt_len), .err_short(err_short), .err_len(err_len), .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    // kind 0 = byte (data, sop, err_seq); 1 = packet (len, err_len); 2 = err_short
    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       a;
        logic       b;
    } ev_t;
    ev_t q[$];
    int  vectors = 0, miscompares = 0;

    function automatic void exp_ev(input int kind, input logic [7:0] d, input logic a, input logic b);
        ev_t e;
        e.kind = kind; e.data = d; e.a = a; e.b = b;
        q.push_back(e);
    endfunction

    task automatic check_ev(input int kind, input logic [7:0] d, input logic a, input logic b);
        ev_t e;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind=%0d data=%h a=%b b=%b, required no event", kind, d, a, b);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.data != d || e.a != a || e.b != b) begin
                miscompares++;
                $display("FAIL event_mismatch: got kind=%0d data=%h a=%b b=%b, required kind=%0d data=%h a=%b b=%b",
                         kind, d, a, b, e.kind, e.data, e.a, e.b);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) check_ev(0, rx_data, rx_sop, err_seq);
            if (err_short) check_ev(2, 8'h00, 1'b0, 1'b0);
            if (pkt_done) check_ev(1, pkt_len, err_len, 1'b0);
            if ((err_seq && !rx_valid) || (err_len && !pkt_done) || (rx_sop && !rx_valid)) begin
                vectors++;
                miscompares++;
                $display("FAIL orphan_flag: got err_seq=%b err_len=%b rx_sop=%b without its strobe, required 0",
                         err_seq, err_len, rx_sop);
            end
        end
    end

    // One CS window carrying the n low bits of b, LSB first, SCK period 4 clk, then 1 clk of CS high.
    task automatic send_win(input logic [7:0] b, input int n);
        spi_csn = 1'b0;
        #20;
        for (int i = 0; i < n; i++) begin
            spi_sdi = b[i];
            #20 spi_sck = 1'b1;
            #20 spi_sck = 1'b0;
        end
        #20 spi_csn = 1'b1;
        #10;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sop, input logic seq);
        exp_ev(0, b, sop, seq);
        send_win(b, 8);
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if ({rx_data, rx_valid, rx_sop, pkt_done, pkt_len, err_short, err_len, err_seq} != 22'd0) begin
            miscompares++;
            $display("FAIL %s: got data=%h v=%b sop=%b done=%b len=%h es=%b el=%b eq=%b, required all 0",
                     name, rx_data, rx_valid, rx_sop, pkt_done, pkt_len, err_short, err_len, err_seq);
        end
    endtask

    initial begin
        logic [7:0] seq5[10];
        seq5 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset_state");
        @(negedge clk) rst = 1'b0;
        #100;

        // basic 10-byte packet
        for (int i = 0; i < 10; i++) send_byte(8'(i), i == 0, 1'b0);
        exp_ev(1, 8'd10, 1'b0, 1'b0);
        #1000;

        // sequence wrap 0xFE, 0xFF, 0x00..0x07
        for (int i = 0; i < 10; i++) send_byte(8'(8'hFE + i), i == 0, 1'b0);
        exp_ev(1, 8'd10, 1'b0, 1'b0);
        #1000;

        // short window, then a full byte in the same packet
        exp_ev(2, 8'h00, 1'b0, 1'b0);
        send_win(8'h1F, 5);
        send_byte(8'h5A, 1'b1, 1'b0);
        exp_ev(1, 8'd1, 1'b1, 1'b0);
        #1000;

        // 7-byte packet -> length error
        for (int i = 0; i < 7; i++) send_byte(8'(i), i == 0, 1'b0);
        exp_ev(1, 8'd7, 1'b1, 1'b0);
        #1000;

        // 0x03 where 0x05 is expected
        for (int i = 0; i < 10; i++) send_byte(seq5[i], i == 0, i == 5);
        exp_ev(1, 8'd10, 1'b0, 1'b0);
        #1000;

        // packet with no complete byte closes silently
        exp_ev(2, 8'h00, 1'b0, 1'b0);
        send_win(8'h07, 3);
        #1000;

        // reset mid-byte with CS low, extra SCK edges ignored until CS seen high
        spi_csn = 1'b0;
        #20;
        for (int i = 0; i < 4; i++) begin
            spi_sdi = i[0];
            #20 spi_sck = 1'b1;
            #20 spi_sck = 1'b0;
        end
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_reset_outputs("reset_midbyte");
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #20 spi_sck = 1'b1;
            #20 spi_sck = 1'b0;
        end
        #40 spi_csn = 1'b1;
        #100;
        for (int i = 0; i < 10; i++) send_byte(8'(i), i == 0, 1'b0);
        exp_ev(1, 8'd10, 1'b0, 1'b0);
        #1000;

        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d events still pending, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/k64_spi_rx.md
K64_SPI_RX -- requirements
Module: k64_spi_rx

Interface
REQ-001 Parameter PKT_LEN, default 10, expected bytes per packet.
REQ-002 Parameter GAP_CYCLES, default 16, synchronized CS-high clk cycles that close a packet.
REQ-003 clk  input  1  system clock; one clock domain; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 spi_csn  input  1  chip select from master, active-low, asynchronous to clk.
REQ-006 spi_sck  input  1  serial clock from master, asynchronous; data sampled on its rising edge.
REQ-007 spi_sdi  input  1  serial data from master, LSB first.
REQ-008 rx_data  output  8  last assembled byte.
REQ-009 rx_valid  output  1  one-cycle pulse; rx_data is valid.
REQ-010 rx_sop  output  1  qualifies rx_valid; byte is first of a packet.
REQ-011 pkt_done  output  1  one-cycle pulse at packet close.
REQ-012 pkt_len  output  8  byte count of the closed packet; valid with pkt_done.
REQ-013 err_short  output  1  one-cycle pulse; CS rose with 1-7 bits pending.
REQ-014 err_len  output  1  one-cycle pulse with pkt_done when pkt_len != PKT_LEN.
REQ-015 err_seq  output  1  one-cycle pulse with rx_valid when a non-first byte != previous byte + 1 (mod 256).

Function
REQ-016 spi_csn, spi_sck and spi_sdi SHALL each pass through a 2-flop synchronizer; sck_rise = synchronized SCK 0->1; clk SHALL be >= 4x SCK.
REQ-017 FSM states: WAIT_HI, IDLE, BYTE, GAP.
REQ-018 WAIT_HI -> IDLE when synchronized CS is high; no SCK edges are processed in WAIT_HI.
REQ-019 IDLE -> BYTE on synchronized CS low; bit_cnt=0; next assembled byte is the packet's first.
REQ-020 BYTE: on sck_rise, shift register bit[bit_cnt] <= sdi_s and bit_cnt increments.
REQ-021 At the 8th sck_rise: rx_valid=1 on the next clk with rx_data = assembled byte; bit_cnt wraps to 0; further bits in the same CS window form further bytes.
REQ-022 BYTE -> GAP on synchronized CS high. If bit_cnt is in 1..7: err_short pulses and the partial byte is discarded. If bit_cnt = 0: no error.
REQ-023 GAP: gap counter increments each CS-high cycle; CS low before GAP_CYCLES -> BYTE, same packet, counter cleared.
REQ-024 GAP counter reaching GAP_CYCLES -> IDLE, pkt_done pulse, pkt_len = byte count; err_len if pkt_len != PKT_LEN.
REQ-025 A packet with zero complete bytes SHALL close silently: no pkt_done, no err_len.
REQ-026 Byte counter saturates at 255.
REQ-027 err_seq: the first byte of a packet seeds the expected value; each later byte compares against previous + 1, wrapping 255 -> 0.
REQ-028 Simultaneous sck_rise and CS-rise in the same synchronized cycle: the SCK bit is counted first; the CS-rise check then uses the updated bit_cnt.
REQ-029 All pulse outputs SHALL be exactly one clk wide; rx_data holds its value between pulses.

Reset
REQ-030 While rst=1: all outputs 0, rx_data=0, counters 0, shift register 0, synchronizers 0, state WAIT_HI.
REQ-031 Reset mid-byte or mid-packet SHALL discard all partial data and emit no pulses. Reception resumes only after CS is seen high.

Structure
REQ-032 Package k64_spi_pkg holds the FSM state enum and the PKT_LEN and GAP_CYCLES defaults.
REQ-033 Sub-module spi_sync_edge (2-flop synchronizer with rise/fall detect) is instantiated once per input.

Verification
REQ-034 Master sends 10 bytes 0x00..0x09, 8 SCK per CS window, 1-cycle CS-high between bytes, then 100-cycle gap -> 10 rx_valid pulses with rx_sop on 0x00 only; pkt_done with pkt_len=10; no errors.
REQ-035 Packet 0xFE,0xFF,0x00..0x07 -> err_seq never asserts; checks the 255 -> 0 wrap.
REQ-036 CS window with 5 SCK edges, then CS high -> err_short one pulse; no rx_valid; following full byte is received correctly.
REQ-037 Packet of 7 correct bytes then gap -> pkt_done with pkt_len=7 and err_len=1.
REQ-038 Byte 0x03 where 0x05 is expected -> err_seq coincident with that byte's rx_valid.
REQ-039 rst asserted after 4 bits with CS held low, released, then CS high and a fresh packet -> no pulses before the new packet; new packet received cleanly.
